// File: rtl/emif_dfh_csr_slave_pkg.sv
// -----------------------------------------------------------------------------
// emif_dfh_csr_slave_pkg
// Shared types and constants for the EMIF device-feature-header CSR slave:
//   t_dfh            - field layout of the 64-bit device feature header
//   OFF_*            - byte offsets of the four mapped 64-bit registers
//   EMIF_FEATURE_ID  - feature ID carried in the EMIF DFH
//   DFH_DEFAULT      - default DFH word (64'h3000_0006_B000_1009)
// -----------------------------------------------------------------------------
package emif_dfh_csr_slave_pkg;

   typedef struct packed {
      logic [3:0]  feature_type;
      logic [18:0] reserved;
      logic        eol;
      logic [23:0] next_dfh_offset;
      logic [3:0]  feature_rev;
      logic [11:0] feature_id;
   } t_dfh;

   localparam logic [7:0] OFF_DFH        = 8'h00;
   localparam logic [7:0] OFF_STATUS     = 8'h08;
   localparam logic [7:0] OFF_CAPABILITY = 8'h10;
   localparam logic [7:0] OFF_SCRATCH    = 8'h18;

   localparam logic [11:0] EMIF_FEATURE_ID = 12'h009;

   localparam t_dfh DFH_DEFAULT = '{
      feature_type    : 4'h3,
      reserved        : 19'h0,
      eol             : 1'b0,
      next_dfh_offset : 24'h06B000,
      feature_rev     : 4'h1,
      feature_id      : EMIF_FEATURE_ID
   };

endpackage

// File: rtl/emif_cal_sync.sv
// -----------------------------------------------------------------------------
// emif_cal_sync
// Two-flop synchronizer for a bus of independent level signals.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low reset (flops clear to 0)
//   d      in  W  asynchronous level inputs
//   q      out W  synchronized levels, two rising edges after d changes
// Each bit is synchronized on its own; no cross-bit coherency is implied.
// -----------------------------------------------------------------------------
module emif_cal_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/emif_dfh_csr_slave.sv
// -----------------------------------------------------------------------------
// emif_dfh_csr_slave
// CSR slave exposing the EMIF device feature header and calibration status.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready = !rsp_valid || rsp_ready
//   req_write, req_addr   1=write / 0=read, byte offset (bits [2:0] ignored)
//   req_wdata, req_be     write data and byte enables (writes only)
//   rsp_valid/rsp_ready   read-response handshake (writes produce no response)
//   rsp_rdata             read data, loaded on the accepting edge
//   cal_success/cal_fail  per-channel calibration levels, asynchronous to clk
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and payload stable until that edge.
// Map: 0x00 DFH (RO), 0x08 STATUS, 0x10 CAPABILITY (RO), 0x18 SCRATCH (RW).
// STATUS[NUM_MEM_CH-1:0] live calibration pass, STATUS[8 +: NUM_MEM_CH]
// sticky calibration fail (write-1-to-clear through byte lane 1).
// -----------------------------------------------------------------------------
module emif_dfh_csr_slave
   import emif_dfh_csr_slave_pkg::*;
#(
   parameter int          NUM_MEM_CH = 4,
   parameter logic [63:0] DFH_VAL    = DFH_DEFAULT,
   parameter logic [7:0]  CAP_MASK   = 8'h0F
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [7:0]            req_addr,
   input  logic [63:0]           req_wdata,
   input  logic [7:0]            req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [63:0]           rsp_rdata,
   input  logic [NUM_MEM_CH-1:0] cal_success,
   input  logic [NUM_MEM_CH-1:0] cal_fail
);

   logic [2*NUM_MEM_CH-1:0] cal_sync;
   logic [NUM_MEM_CH-1:0]   sync_success, sync_fail;

   logic                  rsp_valid_q, rsp_valid_d;
   logic [63:0]           rsp_rdata_q, rsp_rdata_d;
   logic [63:0]           scratch_q, scratch_d;
   logic [NUM_MEM_CH-1:0] fail_q, fail_d;

   logic                  accept, wr_en, rd_en;
   logic                  hit_status, hit_scratch;
   logic [NUM_MEM_CH-1:0] fail_clr;
   logic [63:0]           status_word, rd_data;
   logic                  unused_addr_lsbs;

   // Pass and fail levels share one synchronizer so both see equal latency.
   emif_cal_sync #(.W(2*NUM_MEM_CH)) u_cal_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({cal_fail, cal_success}),
      .q     (cal_sync)
   );

   assign sync_success = cal_sync[NUM_MEM_CH-1:0];
   assign sync_fail    = cal_sync[2*NUM_MEM_CH-1:NUM_MEM_CH];

   // Only 64-bit words are decoded.
   assign unused_addr_lsbs = ^req_addr[2:0];

   assign req_ready   = !rsp_valid_q || rsp_ready;
   assign accept      = req_valid && req_ready;
   assign wr_en       = accept && req_write;
   assign rd_en       = accept && !req_write;
   assign hit_status  = (req_addr[7:3] == OFF_STATUS[7:3]);
   assign hit_scratch = (req_addr[7:3] == OFF_SCRATCH[7:3]);

   // Read mux uses current register values, so a read sees the state that
   // existed before any update made on the same edge.
   always_comb begin
      status_word                   = '0;
      status_word[NUM_MEM_CH-1:0]   = sync_success;
      status_word[8 +: NUM_MEM_CH]  = fail_q;
      rd_data = '0;
      if (req_addr[7:3] == OFF_DFH[7:3]) begin
         rd_data = DFH_VAL;
      end else if (hit_status) begin
         rd_data = status_word;
      end else if (req_addr[7:3] == OFF_CAPABILITY[7:3]) begin
         rd_data = {56'h0, CAP_MASK};
      end else if (hit_scratch) begin
         rd_data = scratch_q;
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      if (rd_en) begin
         // Also covers consume-and-reload in the same cycle.
         rsp_valid_d = 1'b1;
         rsp_rdata_d = rd_data;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      scratch_d = scratch_q;
      for (int i = 0; i < 8; i++) begin
         if (wr_en && hit_scratch && req_be[i]) begin
            scratch_d[8*i +: 8] = req_wdata[8*i +: 8];
         end
      end

      // Fail bits all live in byte lane 1; a concurrent set beats the clear.
      fail_clr = '0;
      if (wr_en && hit_status && req_be[1]) begin
         fail_clr = req_wdata[8 +: NUM_MEM_CH];
      end
      fail_d = (fail_q & ~fail_clr) | sync_fail;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         scratch_q   <= '0;
         fail_q      <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         scratch_q   <= scratch_d;
         fail_q      <= fail_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_emif_dfh_csr_slave.sv
// -----------------------------------------------------------------------------
// tb_emif_dfh_csr_slave
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (status sync latency, sticky W1C, backpressure, reset) and a
// randomized phase scored against a register-level model of the CSR map.
// -----------------------------------------------------------------------------
module tb_emif_dfh_csr_slave;
   import emif_dfh_csr_slave_pkg::*;

   localparam int NCH = 4;
   localparam logic [63:0] DFH_EXP = 64'h3000_0006_B000_1009;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            req_valid, req_ready, req_write;
   logic [7:0]      req_addr, req_be;
   logic [63:0]     req_wdata, rsp_rdata;
   logic            rsp_valid, rsp_ready;
   logic [NCH-1:0]  cal_success, cal_fail;

   emif_dfh_csr_slave #(
      .NUM_MEM_CH (NCH),
      .DFH_VAL    (DFH_EXP),
      .CAP_MASK   (8'h0F)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .cal_success (cal_success),
      .cal_fail    (cal_fail)
   );

   // ---------------- scoreboard / model ----------------
   int tests_run = 0;
   int tests_failed = 0;
   logic [63:0] exp_q[$];

   logic [63:0]    m_scratch;
   logic [NCH-1:0] m_succ, m_fail, m_fail_lvl;
   logic           prev_hold;
   logic [63:0]    prev_data, last_rsp;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_read(input logic [7:0] a);
      logic [4:0]  wi;
      logic [63:0] r;
      wi = a[7:3];
      r  = '0;
      case (wi)
         5'd0: r = DFH_EXP;
         5'd1: begin
            r[NCH-1:0]  = m_succ;
            r[8 +: NCH] = m_fail;
         end
         5'd2: r = 64'h0F;
         5'd3: r = m_scratch;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic void model_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
      logic [4:0] wi;
      wi = a[7:3];
      if (wi == 5'd3) begin
         for (int i = 0; i < 8; i++)
            if (be[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
      end else if (wi == 5'd1 && be[1]) begin
         m_fail = (m_fail & ~d[8 +: NCH]) | m_fail_lvl;
      end
   endfunction

   // ---------------- driver ----------------
   // One cycle: drive at negedge, settle, observe what the next posedge does.
   task automatic step(input logic v, input logic w, input logic [7:0] a,
                       input logic [63:0] d, input logic [7:0] be, input logic rr,
                       input logic use_exp, input logic [63:0] exp_val, output logic acc);
      logic [63:0] e;
      @(negedge clk);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      rsp_ready = rr;
      #1;
      if (prev_hold) begin
         check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
         check("rsp_hold_data", rsp_rdata, prev_data);
      end
      check("req_ready_rule", 64'(req_ready), 64'(!rsp_valid || rr));
      acc = v && req_ready;
      if (rsp_valid && rr) begin
         if (exp_q.size() == 0) begin
            check("spurious_rsp", 64'(rsp_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_rdata, e);
            last_rsp = rsp_rdata;
         end
      end
      prev_hold = rsp_valid && !rr;
      prev_data = rsp_rdata;
      if (acc) begin
         if (w) model_write(a, d, be);
         else   exp_q.push_back(use_exp ? exp_val : model_read(a));
      end
   endtask

   task automatic txn(input logic w, input logic [7:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic use_exp, input logic [63:0] exp_val);
      logic acc;
      acc = 1'b0;
      for (int k = 0; k < 50 && !acc; k++)
         step(1'b1, w, a, d, be, 1'b1, use_exp, exp_val, acc);
      check("txn_accept", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int k = 0; k < n; k++)
         step(1'b0, 1'b0, 8'h0, 64'h0, 8'h0, 1'b1, 1'b0, 64'h0, acc);
   endtask

   task automatic set_cal(input logic [NCH-1:0] succ, input logic [NCH-1:0] fail);
      cal_success = succ;
      cal_fail    = fail;
      idle(3);
      m_succ     = succ;
      m_fail     = m_fail | fail;
      m_fail_lvl = fail;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [63:0] d;
      logic [7:0]  be;
      logic [63:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic acc;
      logic pv, pw;
      logic [7:0]  pa, pbe;
      logic [63:0] pd;
      t_dfh dfh;

      req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
      rsp_ready = 1; cal_success = 0; cal_fail = 0;
      m_scratch = 0; m_succ = 0; m_fail = 0; m_fail_lvl = 0;
      prev_hold = 0; prev_data = 0; last_rsp = 0;

      tbl[0]  = '{1'b1, 8'h18, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 64'h0};
      tbl[1]  = '{1'b0, 8'h18, 64'h0, 8'h00, 64'h0000_0000_CAFE_F00D};
      tbl[2]  = '{1'b0, 8'h10, 64'h0, 8'h00, 64'h0000_0000_0000_000F};
      tbl[3]  = '{1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
      tbl[4]  = '{1'b0, 8'h00, 64'h0, 8'h00, DFH_EXP};
      tbl[5]  = '{1'b1, 8'h1C, 64'h1122_3344_5566_7788, 8'hF0, 64'h0};
      tbl[6]  = '{1'b0, 8'h1F, 64'h0, 8'h00, 64'h1122_3344_CAFE_F00D};
      tbl[7]  = '{1'b1, 8'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
      tbl[8]  = '{1'b0, 8'h40, 64'h0, 8'h00, 64'h0};
      tbl[9]  = '{1'b0, 8'h18, 64'h0, 8'h00, 64'h1122_3344_CAFE_F00D};
      tbl[10] = '{1'b1, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0};
      tbl[11] = '{1'b0, 8'h10, 64'h0, 8'h00, 64'h0000_0000_0000_000F};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_rdata", rsp_rdata, 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd1);
      rst_n = 1'b1;

      // First request accepted on the first edge after reset release
      step(1'b1, 1'b0, 8'h00, 64'h0, 8'h00, 1'b1, 1'b1, DFH_EXP, acc);
      check("first_accept", 64'(acc), 64'd1);
      idle(1);
      dfh = last_rsp;
      check("dfh_feat_id", 64'(dfh.feature_id), 64'h9);

      for (int i = 0; i < 12; i++)
         txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, 1'b1, tbl[i].exp);
      idle(2);

      // Calibration pass visible two edges after the input changes
      cal_success = 4'b1011;
      idle(1);
      m_succ = 4'b1011;
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_000B);
      txn(1'b0, 8'h10, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_000F);
      idle(2);

      // Sticky fail: 3-cycle pulse, W1C, then W1C while the fail is held
      cal_fail = 4'b0100;
      idle(3);
      cal_fail = 4'b0000;
      idle(3);
      m_fail = 4'b0100; m_fail_lvl = 4'b0000;
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_040B);
      txn(1'b1, 8'h08, 64'h400, 8'h02, 1'b0, 64'h0);
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_000B);
      set_cal(4'b1011, 4'b0100);
      txn(1'b1, 8'h08, 64'h400, 8'h02, 1'b0, 64'h0);
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_040B);
      set_cal(4'b1011, 4'b0000);
      txn(1'b1, 8'h08, 64'h400, 8'h01, 1'b0, 64'h0);
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_040B);
      txn(1'b1, 8'h08, 64'h400, 8'h02, 1'b0, 64'h0);
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0000_0000_0000_000B);
      idle(2);

      // Backpressure: second read stalls, first response held stable
      step(1'b1, 1'b0, 8'h00, 64'h0, 8'h0, 1'b0, 1'b1, DFH_EXP, acc);
      check("bp_first_accept", 64'(acc), 64'd1);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 8'h10, 64'h0, 8'h0, 1'b0, 1'b1, 64'h0F, acc);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_rsp_data", rsp_rdata, DFH_EXP);
      end
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++)
         step(1'b1, 1'b0, 8'h10, 64'h0, 8'h0, 1'b1, 1'b1, 64'h0F, acc);
      check("bp_second_accept", 64'(acc), 64'd1);
      idle(2);
      check("bp_drain", 64'(exp_q.size()), 64'd0);

      // Randomized traffic against the register model
      for (int seg = 0; seg < 6; seg++) begin
         set_cal(NCH'($urandom_range(0, 15)), NCH'($urandom_range(0, 15)));
         pv = 0; pw = 0; pa = 0; pd = 0; pbe = 0;
         for (int n = 0; n < 80; n++) begin
            if (!pv && $urandom_range(0, 3) != 0) begin
               int pick;
               pv   = 1'b1;
               pw   = 1'($urandom_range(0, 1));
               pick = $urandom_range(0, 5);
               if (pick < 4)       pa = {3'b000, pick[1:0], 3'($urandom_range(0, 7))};
               else if (pick == 4) pa = 8'($urandom_range(8'h20, 8'hFF));
               else                pa = 8'($urandom_range(0, 255));
               pd  = {$urandom, $urandom};
               pbe = 8'($urandom_range(0, 255));
            end
            step(pv, pw, pa, pd, pbe, ($urandom_range(0, 9) < 7), 1'b0, 64'h0, acc);
            if (acc) pv = 1'b0;
         end
         idle(4);
         check("rand_drain", 64'(exp_q.size()), 64'd0);
      end

      // Reset while a response is pending
      set_cal(4'b0000, 4'b0000);
      txn(1'b1, 8'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 64'h0);
      step(1'b1, 1'b0, 8'h08, 64'h0, 8'h0, 1'b0, 1'b0, 64'h0, acc);
      @(negedge clk);
      #2;
      check("pre_reset_valid", 64'(rsp_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("reset_drop_valid", 64'(rsp_valid), 64'd0);
      check("reset_drop_rdata", rsp_rdata, 64'd0);
      check("reset_drop_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b0; rsp_ready = 1'b1;
      exp_q.delete();
      prev_hold = 1'b0;
      m_scratch = 0; m_fail = 0; m_succ = 0; m_fail_lvl = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);
      txn(1'b0, 8'h18, 64'h0, 8'h0, 1'b1, 64'h0);
      txn(1'b0, 8'h40, 64'h0, 8'h0, 1'b1, 64'h0);
      txn(1'b0, 8'h08, 64'h0, 8'h0, 1'b1, 64'h0);
      idle(3);
      check("final_drain", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
